// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and helpers for the HD44780 hex writer.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam int         NUM_INIT     = 4;
  localparam int         NUM_CHARS    = 8;

  typedef enum logic [2:0] {POWERUP, INIT, SET_ADDR, CHAR, DONE} lcd_state_t;
  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_EN, PH_WAIT} lcd_phase_t;

  function automatic logic [7:0] init_cmd(input logic [3:0] idx);
    case (idx)
      4'd0:    init_cmd = CMD_FUNC_SET;
      4'd1:    init_cmd = CMD_DISP_ON;
      4'd2:    init_cmd = CMD_CLEAR;
      4'd3:    init_cmd = CMD_ENTRY;
      default: init_cmd = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    hex_ascii = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// One HD44780 bus transfer: setup cycle, EN pulse, then a hold/wait period.
// o_done marks the last wait cycle so a new start can follow with no idle gap.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int EN_CYCLES         = 16,
  parameter int WAIT_CYCLES       = 2500,
  parameter int CLEAR_WAIT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic       i_rs,
  input  logic [7:0] i_byte,
  input  logic       i_long_wait,
  output logic       o_done,
  output logic [7:0] o_data,
  output logic       o_rs,
  output logic       o_en
);

  localparam int MAX_CNT = (CLEAR_WAIT_CYCLES > WAIT_CYCLES)
                         ? ((CLEAR_WAIT_CYCLES > EN_CYCLES) ? CLEAR_WAIT_CYCLES : EN_CYCLES)
                         : ((WAIT_CYCLES > EN_CYCLES) ? WAIT_CYCLES : EN_CYCLES);
  localparam int CW = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] EN_LAST    = CW'(EN_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_WAIT_CYCLES - 1);

  lcd_phase_t    r_ph, w_ph_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_en, w_en_nxt;
  logic [7:0]    r_data;
  logic          r_rs, r_long;

  assign o_done = (r_ph == PH_WAIT) && (r_cnt == (r_long ? CLEAR_LAST : WAIT_LAST));
  assign o_data = r_data;
  assign o_rs   = r_rs;
  assign o_en   = r_en;

  always_comb begin
    w_ph_nxt  = r_ph;
    w_cnt_nxt = r_cnt;
    w_en_nxt  = r_en;
    if (i_start) begin
      w_ph_nxt  = PH_SETUP;
      w_cnt_nxt = '0;
      w_en_nxt  = 1'b0;
    end else begin
      case (r_ph)
        PH_SETUP: begin
          w_ph_nxt  = PH_EN;
          w_en_nxt  = 1'b1;
          w_cnt_nxt = '0;
        end
        PH_EN: begin
          if (r_cnt == EN_LAST) begin
            w_ph_nxt  = PH_WAIT;
            w_en_nxt  = 1'b0;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        PH_WAIT: begin
          if (o_done) begin
            w_ph_nxt  = PH_IDLE;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ph   <= PH_IDLE;
      r_cnt  <= '0;
      r_en   <= 1'b0;
      r_data <= 8'h00;
      r_rs   <= 1'b0;
      r_long <= 1'b0;
    end else begin
      r_ph  <= w_ph_nxt;
      r_cnt <= w_cnt_nxt;
      r_en  <= w_en_nxt;
      if (i_start) begin
        r_data <= i_byte;
        r_rs   <= i_rs;
        r_long <= i_long_wait;
      end
    end
  end

endmodule

// File: rtl/lcd_hex_writer.sv
// Drives an HD44780 panel: power-up delay, init commands, then endlessly
// rewrites line 1 with the 8 hex digits of a per-frame snapshot of lcd_data.
module lcd_hex_writer
  import lcd_pkg::*;
#(
  parameter int EN_CYCLES         = 16,
  parameter int WAIT_CYCLES       = 2500,
  parameter int CLEAR_WAIT_CYCLES = 100000,
  parameter int INIT_WAIT_CYCLES  = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lcd_data,
  output logic [7:0]  LCD_DATA,
  output logic        LCD_RS,
  output logic        LCD_EN,
  output logic        LCD_RW,
  output logic        LCD_ON,
  output logic        LCD_BLON,
  output logic        init_done,
  output logic        frame_done
);

  localparam int PW = $clog2(INIT_WAIT_CYCLES + 1);
  localparam logic [PW-1:0] PWR_LAST = PW'(INIT_WAIT_CYCLES - 1);

  lcd_state_t  r_state, w_state_nxt;
  logic [PW-1:0] r_pcnt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic [31:0] r_snap;
  logic        r_init_done;
  logic        w_start, w_rs, w_long, w_done, w_snap_ld, w_init_set;
  logic [7:0]  w_byte;
  logic [2:0]  w_nib_sel;
  logic [3:0]  w_nib;

  assign LCD_RW     = 1'b0;
  assign LCD_ON     = 1'b1;
  assign LCD_BLON   = 1'b1;
  assign init_done  = r_init_done;
  assign frame_done = (r_state == DONE);

  // Digit k of the line shows snapshot nibble 7-k (most significant first).
  assign w_nib_sel = 3'(4'd7 - r_idx);
  assign w_nib     = r_snap[{w_nib_sel, 2'b00} +: 4];
  assign w_long    = !w_rs && (w_byte == CMD_CLEAR);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_start     = 1'b0;
    w_rs        = 1'b0;
    w_byte      = 8'h00;
    w_snap_ld   = 1'b0;
    w_init_set  = 1'b0;
    case (r_state)
      POWERUP: if (r_pcnt == PWR_LAST) begin
        w_start     = 1'b1;
        w_byte      = CMD_FUNC_SET;
        w_idx_nxt   = 4'd1;
        w_state_nxt = INIT;
      end
      INIT: if (w_done) begin
        w_start = 1'b1;
        if (r_idx == 4'(NUM_INIT)) begin
          w_byte      = CMD_LINE1;
          w_snap_ld   = 1'b1;
          w_init_set  = 1'b1;
          w_state_nxt = SET_ADDR;
        end else begin
          w_byte    = init_cmd(r_idx);
          w_idx_nxt = r_idx + 4'd1;
        end
      end
      SET_ADDR: if (w_done) begin
        w_start     = 1'b1;
        w_rs        = 1'b1;
        w_byte      = hex_ascii(r_snap[31:28]);
        w_idx_nxt   = 4'd1;
        w_state_nxt = CHAR;
      end
      CHAR: if (w_done) begin
        if (r_idx == 4'(NUM_CHARS)) begin
          w_idx_nxt   = 4'd0;
          w_state_nxt = DONE;
        end else begin
          w_start   = 1'b1;
          w_rs      = 1'b1;
          w_byte    = hex_ascii(w_nib);
          w_idx_nxt = r_idx + 4'd1;
        end
      end
      DONE: begin
        w_start     = 1'b1;
        w_byte      = CMD_LINE1;
        w_snap_ld   = 1'b1;
        w_state_nxt = SET_ADDR;
      end
      default: w_state_nxt = POWERUP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= POWERUP;
      r_pcnt      <= '0;
      r_idx       <= 4'd0;
      r_snap      <= 32'h0;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (r_state == POWERUP && r_pcnt != PWR_LAST) r_pcnt <= r_pcnt + 1'b1;
      if (w_snap_ld)  r_snap      <= lcd_data;
      if (w_init_set) r_init_done <= 1'b1;
    end
  end

  lcd_byte_writer #(
    .EN_CYCLES        (EN_CYCLES),
    .WAIT_CYCLES      (WAIT_CYCLES),
    .CLEAR_WAIT_CYCLES(CLEAR_WAIT_CYCLES)
  ) u_bw (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_start),
    .i_rs       (w_rs),
    .i_byte     (w_byte),
    .i_long_wait(w_long),
    .o_done     (w_done),
    .o_data     (LCD_DATA),
    .o_rs       (LCD_RS),
    .o_en       (LCD_EN)
  );

endmodule

// File: tb/tb_lcd_hex_writer.sv
// Scoreboard bench: stimulus queues the expected byte stream, a bus monitor
// checks bytes, EN width, inter-transfer gaps, init_done and frame_done.
module tb_lcd_hex_writer;

  localparam int EN_C  = 2;
  localparam int WT_C  = 4;
  localparam int CLR_C = 8;
  localparam int INI_C = 10;
  localparam int TMO   = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lcd_data;
  logic [7:0]  LCD_DATA;
  logic        LCD_RS, LCD_EN, LCD_RW, LCD_ON, LCD_BLON, init_done, frame_done;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] b;
    logic       rs;
    int         gap;   // EN-low samples from this EN fall to the next EN rise
    logic       init;  // expected init_done while this byte is strobed
  } xfer_t;
  xfer_t exp_q[$];

  lcd_hex_writer #(
    .EN_CYCLES(EN_C), .WAIT_CYCLES(WT_C),
    .CLEAR_WAIT_CYCLES(CLR_C), .INIT_WAIT_CYCLES(INI_C)
  ) dut (
    .clk(clk), .reset(reset), .lcd_data(lcd_data),
    .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_EN(LCD_EN), .LCD_RW(LCD_RW),
    .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON),
    .init_done(init_done), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic xfer_t mk(input logic [7:0] b, input logic rs, input int gap, input logic ini);
    xfer_t x;
    x.b = b; x.rs = rs; x.gap = gap; x.init = ini;
    return x;
  endfunction

  task automatic push_init();
    exp_q.push_back(mk(8'h38, 1'b0, WT_C + 1, 1'b0));
    exp_q.push_back(mk(8'h0C, 1'b0, WT_C + 1, 1'b0));
    exp_q.push_back(mk(8'h01, 1'b0, CLR_C + 1, 1'b0));
    exp_q.push_back(mk(8'h06, 1'b0, WT_C + 1, 1'b0));
  endtask

  // Line 1 address, then eight hex digits, most significant first; the
  // one-cycle DONE state adds a single extra idle cycle after the last digit.
  task automatic push_frame(input logic [31:0] v);
    int d;
    exp_q.push_back(mk(8'h80, 1'b0, WT_C + 1, 1'b1));
    for (int k = 7; k >= 0; k--) begin
      d = (v / (32'd1 << (4 * k))) % 16;
      exp_q.push_back(mk((d < 10) ? 8'(48 + d) : 8'(65 + d - 10), 1'b1,
                         (k == 0) ? WT_C + 2 : WT_C + 1, 1'b1));
    end
  endtask

  // Bus monitor
  logic       m_prev_en, m_prev_fd, m_have_prev, m_lat_rs;
  logic [7:0] m_lat_d;
  int         m_hi, m_lo, m_gap, m_chars;
  xfer_t      m_x;

  always @(negedge clk) begin
    if (reset) begin
      m_prev_en = 1'b0; m_prev_fd = 1'b0; m_have_prev = 1'b0;
      m_hi = 0; m_lo = 0; m_gap = 0; m_chars = 0;
    end else begin
      chk("rw_low", 32'(LCD_RW), 32'd0);
      if (LCD_EN && !m_prev_en) begin
        if (m_have_prev) chk("gap_before_strobe", m_lo, m_gap);
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 32'(LCD_DATA), 32'hFFFF_FFFF);
        end else begin
          m_x = exp_q.pop_front();
          chk("byte", 32'(LCD_DATA), 32'(m_x.b));
          chk("rs", 32'(LCD_RS), 32'(m_x.rs));
          chk("init_done", 32'(init_done), 32'(m_x.init));
          m_gap = m_x.gap;
        end
        m_have_prev = 1'b1;
        m_lat_d = LCD_DATA; m_lat_rs = LCD_RS; m_hi = 1;
        if (LCD_RS) m_chars++;
        else if (LCD_DATA == 8'h80) m_chars = 0;
      end else if (LCD_EN) begin
        m_hi++;
        chk("data_stable_en", {23'd0, LCD_RS, LCD_DATA}, {23'd0, m_lat_rs, m_lat_d});
      end else if (m_prev_en) begin
        chk("en_width", m_hi, EN_C);
        m_lo = 1;
      end else begin
        m_lo++;
      end
      if (frame_done) begin
        chk("frame_done_pulse", 32'(m_prev_fd), 32'd0);
        chk("chars_per_frame", m_chars, 8);
      end
      m_prev_fd = frame_done;
      m_prev_en = LCD_EN;
    end
  end

  task automatic wait_chars(input int n);
    int seen = 0;
    logic pe = LCD_EN;
    for (int t = 0; t < TMO && seen < n; t++) begin
      @(negedge clk);
      if (LCD_EN && !pe && LCD_RS) seen++;
      pe = LCD_EN;
    end
    if (seen < n) chk("timeout_chars", seen, n);
  endtask

  task automatic wait_fd();
    int t = 0;
    do begin @(negedge clk); t++; end while (!frame_done && t < TMO);
    if (!frame_done) chk("timeout_frame_done", 0, 1);
  endtask

  task automatic check_reset_state();
    chk("rst_en", 32'(LCD_EN), 0);
    chk("rst_data", 32'(LCD_DATA), 0);
    chk("rst_rs", 32'(LCD_RS), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_on_blon", {LCD_ON, LCD_BLON}, 32'd3);
  endtask

  task automatic release_and_check_powerup(input logic [31:0] v);
    int n = 0;
    exp_q.delete();
    push_init();
    push_frame(v);
    @(negedge clk);
    reset = 1'b0;
    do begin @(negedge clk); n++; end while (!LCD_EN && n < TMO);
    chk("powerup_edges_to_en", n, INI_C + 1);
  endtask

  // Frames after the first: lcd_data changes after the 3rd digit, so it
  // must only show up in the following frame.
  task automatic run_frames(input int nf, input bit first_all_f);
    logic [31:0] cur;
    cur = lcd_data;
    for (int f = 0; f < nf; f++) begin
      wait_chars(3);
      cur = (first_all_f && f == 0) ? 32'hFFFF_FFFF : $urandom;
      lcd_data = cur;
      wait_fd();
      push_frame(cur);
    end
  endtask

  initial begin
    reset = 1'b1;
    lcd_data = 32'h1234_ABCF;
    #1;
    check_reset_state();
    repeat (3) @(negedge clk);
    release_and_check_powerup(lcd_data);
    run_frames(5, 1'b1);

    // Reset in the middle of an EN pulse
    begin
      int t = 0;
      do begin @(negedge clk); t++; end while (!LCD_EN && t < TMO);
      chk("en_seen_before_reset", 32'(LCD_EN), 1);
      reset = 1'b1;
      #1;
      check_reset_state();
    end
    repeat (3) @(negedge clk);
    release_and_check_powerup(lcd_data);
    run_frames(3, 1'b0);

    wait_chars(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
